// File: rtl/register_file_pkg.sv
// Shared core constants for the rename/register-file slice: ROB tag width and register count.
// Other files pull these in with a wildcard import so the widths are never restated locally.
package register_file_pkg;
  localparam int ROB_INDEX_BIT = 4;
  localparam int REG_NUM       = 32;
  localparam int REG_IDX_W     = $clog2(REG_NUM);
endpackage

// File: rtl/register_file_if.sv
// Issue, commit and dual read-port bundle between the dispatch/ROB logic and the register file.
// The slave modport is the register file side; the master modport is its driver.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int ROB_IDX_W = ROB_INDEX_BIT,
  parameter int XLEN      = 32
);
  logic                 iss_req;
  logic [REG_IDX_W-1:0] iss_rd;
  logic [ROB_IDX_W-1:0] iss_rob_id;

  logic [REG_IDX_W-1:0] cm_rd;
  logic [XLEN-1:0]      cm_val;
  logic [ROB_IDX_W-1:0] cm_rob_id;

  logic [REG_IDX_W-1:0] rs1_idx;
  logic [REG_IDX_W-1:0] rs2_idx;
  logic [XLEN-1:0]      rs1_val;
  logic [XLEN-1:0]      rs2_val;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [ROB_IDX_W-1:0] rs1_dep;
  logic [ROB_IDX_W-1:0] rs2_dep;

  modport master (
    output iss_req, iss_rd, iss_rob_id,
    output cm_rd, cm_val, cm_rob_id,
    output rs1_idx, rs2_idx,
    input  rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_dep, rs2_dep
  );

  modport slave (
    input  iss_req, iss_rd, iss_rob_id,
    input  cm_rd, cm_val, cm_rob_id,
    input  rs1_idx, rs2_idx,
    output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_dep, rs2_dep
  );
endinterface

// File: rtl/register_file_rf_read_port.sv
// One combinational read port: x0 masking plus optional same-cycle commit forwarding (RF_COMMIT_BYPASS_EN).
// Zero latency, no flow control; the commit inputs exist only when the bypass is built in.
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int ROB_IDX_W = ROB_INDEX_BIT,
  parameter int XLEN      = 32
) (
  input  logic [REG_IDX_W-1:0] i_idx,
  input  logic [XLEN-1:0]      i_reg_val,
  input  logic                 i_reg_busy,
  input  logic [ROB_IDX_W-1:0] i_reg_dep,
`ifdef RF_COMMIT_BYPASS_EN
  input  logic [REG_IDX_W-1:0] i_cm_rd,
  input  logic [XLEN-1:0]      i_cm_val,
  input  logic [ROB_IDX_W-1:0] i_cm_rob_id,
`endif
  output logic [XLEN-1:0]      o_val,
  output logic                 o_busy,
  output logic [ROB_IDX_W-1:0] o_dep
);
`ifdef RF_COMMIT_BYPASS_EN
  logic w_hit;
  // The producer is retiring right now: hand its value straight through.
  assign w_hit = i_reg_busy && (i_cm_rd == i_idx) && (i_cm_rob_id == i_reg_dep);
`endif

  always_comb begin
    o_val  = i_reg_val;
    o_busy = i_reg_busy;
    o_dep  = i_reg_dep;
`ifdef RF_COMMIT_BYPASS_EN
    if (w_hit) begin
      o_val  = i_cm_val;
      o_busy = 1'b0;
    end
`endif
    if (i_idx == '0) begin
      o_val  = '0;
      o_busy = 1'b0;
      o_dep  = '0;
    end
  end
endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tag (busy/dep); optional RF_COMMIT_BYPASS_EN forwarding.
// Reads are combinational; writes land on the next edge; rdy_in low freezes all state.
module register_file
  import register_file_pkg::*;
#(
  parameter int ROB_IDX_W = ROB_INDEX_BIT,
  parameter int XLEN      = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  register_file_if.slave    bus
);
  logic [XLEN-1:0]      r_regs [REG_NUM];
  logic [ROB_IDX_W-1:0] r_dep  [REG_NUM];
  logic [REG_NUM-1:0]   r_busy;

  logic w_cm_wr;
  logic w_cm_release;
  logic w_iss_wr;

  assign w_cm_wr      = (bus.cm_rd != '0);
  assign w_cm_release = w_cm_wr && r_busy[bus.cm_rd] && (r_dep[bus.cm_rd] == bus.cm_rob_id);
  assign w_iss_wr     = bus.iss_req && (bus.iss_rd != '0);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
        r_dep[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (w_cm_wr) begin
        r_regs[bus.cm_rd] <= bus.cm_val;
      end
      if (clear_in) begin
        r_busy <= '0;
        for (int i = 0; i < REG_NUM; i++) begin
          r_dep[i] <= '0;
        end
      end else begin
        if (w_cm_release) begin
          r_busy[bus.cm_rd] <= 1'b0;
        end
        // A rename issued in the same cycle overrides the release above.
        if (w_iss_wr) begin
          r_busy[bus.iss_rd] <= 1'b1;
          r_dep[bus.iss_rd]  <= bus.iss_rob_id;
        end
      end
    end
  end

  rf_read_port #(.ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)) u_rs1 (
    .i_idx       (bus.rs1_idx),
    .i_reg_val   (r_regs[bus.rs1_idx]),
    .i_reg_busy  (r_busy[bus.rs1_idx]),
    .i_reg_dep   (r_dep[bus.rs1_idx]),
`ifdef RF_COMMIT_BYPASS_EN
    .i_cm_rd     (bus.cm_rd),
    .i_cm_val    (bus.cm_val),
    .i_cm_rob_id (bus.cm_rob_id),
`endif
    .o_val       (bus.rs1_val),
    .o_busy      (bus.rs1_busy),
    .o_dep       (bus.rs1_dep)
  );

  rf_read_port #(.ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)) u_rs2 (
    .i_idx       (bus.rs2_idx),
    .i_reg_val   (r_regs[bus.rs2_idx]),
    .i_reg_busy  (r_busy[bus.rs2_idx]),
    .i_reg_dep   (r_dep[bus.rs2_idx]),
`ifdef RF_COMMIT_BYPASS_EN
    .i_cm_rd     (bus.cm_rd),
    .i_cm_val    (bus.cm_val),
    .i_cm_rob_id (bus.cm_rob_id),
`endif
    .o_val       (bus.rs2_val),
    .o_busy      (bus.rs2_busy),
    .o_dep       (bus.rs2_dep)
  );
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed rename/commit/flush/reset cases, then random traffic.
// Expected reads come from an array model of the architectural state; a negedge monitor compares.
module tb_register_file;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_in;

  register_file_if bus ();

  register_file dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear_in (clear_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] v1;
    logic        b1;
    logic [3:0]  d1;
    bit          dc1;
    logic [31:0] v2;
    logic        b2;
    logic [3:0]  d2;
    bit          dc2;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];

  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [3:0]  m_dep  [32];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Expected read: registered state, optionally forwarded from a matching commit, x0 forced to zero.
  task automatic model_read(input bit rst, input logic [4:0] idx, input logic [4:0] crd,
                            input logic [31:0] cval, input logic [3:0] ctag,
                            output logic [31:0] v, output logic b, output logic [3:0] d, output bit dc);
    if (!rst || idx == 5'd0) begin
      v = 32'd0; b = 1'b0; d = 4'd0; dc = 1'b1;
    end else begin
      v = m_val[idx]; b = m_busy[idx]; d = m_dep[idx]; dc = m_busy[idx];
`ifdef RF_COMMIT_BYPASS_EN
      if (m_busy[idx] && crd == idx && ctag == m_dep[idx]) begin
        v = cval; b = 1'b0; dc = 1'b0;
      end
`endif
    end
  endtask

  task automatic step(input string nm, input bit rst, input bit rdy, input bit clr,
                      input bit ir, input logic [4:0] ird, input logic [3:0] itag,
                      input logic [4:0] crd, input logic [31:0] cval, input logic [3:0] ctag,
                      input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    @(posedge clk_in);
    #1;
    rst_in         = rst;
    rdy_in         = rdy;
    clear_in       = clr;
    bus.iss_req    = ir;
    bus.iss_rd     = ird;
    bus.iss_rob_id = itag;
    bus.cm_rd      = crd;
    bus.cm_val     = cval;
    bus.cm_rob_id  = ctag;
    bus.rs1_idx    = r1;
    bus.rs2_idx    = r2;
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'd0; m_busy[i] = 1'b0; m_dep[i] = 4'd0;
      end
    end
    model_read(rst, r1, crd, cval, ctag, e.v1, e.b1, e.d1, e.dc1);
    model_read(rst, r2, crd, cval, ctag, e.v2, e.b2, e.d2, e.dc2);
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (rst && rdy) begin
      if (crd != 5'd0) m_val[crd] = cval;
      if (clr) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 1'b0; m_dep[i] = 4'd0;
        end
      end else begin
        if (crd != 5'd0 && m_busy[crd] && m_dep[crd] == ctag) m_busy[crd] = 1'b0;
        if (ir && ird != 5'd0) begin
          m_busy[ird] = 1'b1; m_dep[ird] = itag;
        end
      end
    end
  endtask

  task automatic nop_read(input string nm, input logic [4:0] r1, input logic [4:0] r2);
    step(nm, 1, 1, 0, 0, 5'd0, 4'd0, 5'd0, 32'd0, 4'd0, r1, r2);
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk_in);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, ".rs1_val"},  bus.rs1_val,  e.v1);
        chk({nm, ".rs1_busy"}, {31'd0, bus.rs1_busy}, {31'd0, e.b1});
        if (e.dc1) chk({nm, ".rs1_dep"}, {28'd0, bus.rs1_dep}, {28'd0, e.d1});
        chk({nm, ".rs2_val"},  bus.rs2_val,  e.v2);
        chk({nm, ".rs2_busy"}, {31'd0, bus.rs2_busy}, {31'd0, e.b2});
        if (e.dc2) chk({nm, ".rs2_dep"}, {28'd0, bus.rs2_dep}, {28'd0, e.d2});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [4:0]  ird, crd, r1, r2;
    logic [3:0]  itag, ctag;
    logic [31:0] cval;
    bit          ir, rdy, clr;
    int          waited;
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    bus.iss_req = 1'b0; bus.iss_rd = '0; bus.iss_rob_id = '0;
    bus.cm_rd = '0; bus.cm_val = '0; bus.cm_rob_id = '0;
    bus.rs1_idx = '0; bus.rs2_idx = '0;

    step("reset", 0, 1, 0, 1, 5'd5, 4'd3, 5'd5, 32'h77, 4'd0, 5'd5, 5'd0);
    // Rename then commit of x5.
    step("iss5",   1, 1, 0, 1, 5'd5, 4'd3, 5'd0, 32'd0, 4'd0, 5'd5, 5'd0);
    nop_read("busy5", 5'd5, 5'd5);
    step("cm5",    1, 1, 0, 0, 5'd0, 4'd0, 5'd5, 32'hDEAD, 4'd3, 5'd5, 5'd0);
    nop_read("after_cm5", 5'd5, 5'd0);
    // Younger rename survives an older commit.
    step("iss7a",  1, 1, 0, 1, 5'd7, 4'd2, 5'd0, 32'd0, 4'd0, 5'd0, 5'd0);
    step("iss7b",  1, 1, 0, 1, 5'd7, 4'd6, 5'd0, 32'd0, 4'd0, 5'd7, 5'd0);
    step("cm7",    1, 1, 0, 0, 5'd0, 4'd0, 5'd7, 32'd1, 4'd2, 5'd7, 5'd0);
    nop_read("after_cm7", 5'd7, 5'd5);
    // Same-cycle issue and commit on x9.
    step("iss_cm9", 1, 1, 0, 1, 5'd9, 4'd4, 5'd9, 32'd8, 4'd1, 5'd9, 5'd7);
    nop_read("after9", 5'd9, 5'd0);
    // Fill every register busy, then flush with a commit and a dropped issue.
    for (int r = 1; r < 32; r++)
      step("fill", 1, 1, 0, 1, 5'(r), 4'(r), 5'd0, 32'd0, 4'd0, 5'(r - 1), 5'd0);
    nop_read("filled", 5'd31, 5'd3);
    step("clear",  1, 1, 1, 1, 5'd10, 4'd5, 5'd3, 32'h55, 4'd9, 5'd3, 5'd10);
    nop_read("after_clr", 5'd3, 5'd10);
    nop_read("after_clr2", 5'd31, 5'd1);
    // Commit forwarding window on x4.
    step("iss4",   1, 1, 0, 1, 5'd4, 4'd2, 5'd0, 32'd0, 4'd0, 5'd0, 5'd0);
    step("cm4",    1, 1, 0, 0, 5'd0, 4'd0, 5'd4, 32'h10, 4'd2, 5'd4, 5'd4);
    nop_read("after_cm4", 5'd4, 5'd0);
    // rdy_in low freezes state.
    step("stall",  1, 0, 0, 1, 5'd6, 4'd9, 5'd5, 32'hBAD, 4'd0, 5'd6, 5'd5);
    nop_read("after_stall", 5'd6, 5'd5);
    step("stall_clr", 1, 0, 1, 0, 5'd0, 4'd0, 5'd0, 32'd0, 4'd0, 5'd7, 5'd0);
    nop_read("after_stall_clr", 5'd7, 5'd9);
    // x0 is immune to issue and commit.
    step("x0",     1, 1, 0, 1, 5'd0, 4'd7, 5'd0, 32'h123, 4'd7, 5'd0, 5'd0);
    nop_read("after_x0", 5'd0, 5'd0);
    // Asynchronous reset mid-sequence.
    step("iss12",  1, 1, 0, 1, 5'd12, 4'd11, 5'd0, 32'd0, 4'd0, 5'd12, 5'd9);
    step("rst_mid", 0, 1, 0, 1, 5'd12, 4'd1, 5'd9, 32'h99, 4'd4, 5'd12, 5'd9);
    nop_read("after_rst", 5'd12, 5'd9);

    for (int n = 0; n < 400; n++) begin
      ir   = ($urandom_range(0, 2) != 0);
      ird  = 5'($urandom_range(0, 7));
      itag = 4'($urandom_range(0, 15));
      crd  = 5'($urandom_range(0, 7));
      ctag = ($urandom_range(0, 1) == 1) ? m_dep[crd] : 4'($urandom_range(0, 15));
      cval = $urandom;
      rdy  = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 19) == 0);
      r1   = ($urandom_range(0, 1) == 1) ? crd : 5'($urandom_range(0, 7));
      r2   = 5'($urandom_range(0, 7));
      step("rand", 1, rdy, clr, ir, ird, itag, crd, cval, ctag, r1, r2);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk_in);
      waited++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter ROB_IDX_W, default 4, giving the ROB tag width; it equals the shared ROB index width constant.
REQ-002 SHALL have parameter XLEN, default 32, giving the data width.
REQ-003 SHALL have port clk_in  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rdy_in  input  1  global ready; when low, state is held.
REQ-006 SHALL have port clear_in  input  1  misprediction flush from the reorder buffer.
REQ-007 SHALL have port iss_req  input  1  an instruction is issued this cycle.
REQ-008 SHALL have port iss_rd  input  5  destination register of the issued instruction.
REQ-009 SHALL have port iss_rob_id  input  ROB_IDX_W  ROB tail tag given to the issued instruction.
REQ-010 SHALL have port cm_rd  input  5  committing destination register; 0 means no write.
REQ-011 SHALL have port cm_val  input  XLEN  committed value.
REQ-012 SHALL have port cm_rob_id  input  ROB_IDX_W  tag of the committing entry.
REQ-013 SHALL have port rs1_idx / rs2_idx  input  5 each  source register indices.
REQ-014 SHALL have port rs1_val / rs2_val  output  XLEN each  architectural value, or forwarded value.
REQ-015 SHALL have port rs1_busy / rs2_busy  output  1 each  source awaits an in-flight producer.
REQ-016 SHALL have port rs1_dep / rs2_dep  output  ROB_IDX_W each  producer tag; valid only when busy.

Function
REQ-017 SHALL hold 32 registers of XLEN bits, each with a busy bit and a dep tag.
REQ-018 SHALL hardwire x0: reads give val=0, busy=0, dep=0; writes, issues and commits to x0 are ignored.
REQ-019 SHALL, on a commit with cm_rd!=0, write cm_val into reg[cm_rd] at the next edge, unconditionally.
REQ-020 SHALL, on that commit, clear busy[cm_rd] only if busy[cm_rd]=1 and dep[cm_rd]==cm_rob_id; a younger rename is kept.
REQ-021 SHALL, on iss_req with iss_rd!=0, set busy[iss_rd]=1 and dep[iss_rd]=iss_rob_id at the next edge.
REQ-022 SHALL, on issue and commit to the same register in one cycle, let the issue win for busy/dep; the value write still occurs.
REQ-023 SHALL, when clear_in=1, clear all busy bits and dep tags at the next edge and ignore iss_req that cycle.
REQ-024 SHALL still perform a commit value write presented in the same cycle as clear_in.
REQ-025 SHALL, when rdy_in=0, change no state; read outputs remain combinational on the current state.
REQ-026 SHALL drive the read ports combinationally, with zero latency, from rsN_idx.
REQ-027 SHALL raise no busy on a read from an issue presented in the same cycle; the issue stage handles intra-cycle dependences.

Reset
REQ-028 SHALL, while rst_in=0, asynchronously force all registers to 0, all busy bits to 0 and all dep tags to 0.
REQ-029 SHALL, with all outputs combinational, present val=0, busy=0, dep=0 on every read during reset.
REQ-030 SHALL resume normal operation at the first rising edge after rst_in deasserts, with no further initialisation cycles.

Configuration
REQ-031 SHALL provide the macro RF_COMMIT_BYPASS_EN.
REQ-032 SHALL, with the macro defined, forward on a read when busy[idx]=1, cm_rd==idx!=0 and cm_rob_id==dep[idx]: rsN_val=cm_val, rsN_busy=0.
REQ-033 SHALL, without the macro, drive reads from registered state only, so the value appears one cycle after the commit.

Structure
REQ-034 SHALL take ROB_INDEX_BIT and the register count (32) from the shared constants package; these are not redefined locally.
REQ-035 SHALL contain one sub-module, rf_read_port, instantiated twice; it holds the x0 masking and commit-bypass logic.

Verification
REQ-036 SHALL cover: issue rd=5 tag=3; next cycle read rs1=5 -> busy=1, dep=3; commit rd=5 tag=3 val=0xDEAD -> read gives busy=0, val=0xDEAD.
REQ-037 SHALL cover: issue x7 tag=2, then issue x7 tag=6; commit x7 tag=2 val=1 -> reg[7]=1, busy=1, dep=6.
REQ-038 SHALL cover: same-cycle issue x9 tag=4 and commit x9 tag=1 val=8 -> busy=1, dep=4, reg[9]=8.
REQ-039 SHALL cover: busy on x1..x31, then clear_in=1 with commit x3 val=0x55 -> all busy=0, reg[3]=0x55, same-cycle issue dropped.
REQ-040 SHALL cover: with RF_COMMIT_BYPASS_EN, x4 busy tag=2, commit x4 tag=2 val=0x10 while reading x4 -> same cycle val=0x10, busy=0; without the macro, busy=1 that cycle.
REQ-041 SHALL cover: issue/commit to x0 and rst_in pulsed low mid-sequence -> x0 reads 0, never busy; all state is zero immediately, without waiting for a clock edge.
